// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address and no clock stretching.
// SCL is input-only. SDA is only ever pulled low or released.
// Ports:
//   clk_i, rst_ni       system clock, asynchronous active-low reset
//   i2c_scl             raw bus clock
//   i2c_sda             bus data, open-drain (driven 0 or released to 'z)
//   rx_data_o/rx_valid_o   received write byte, with a one-cycle valid pulse
//   tx_data_i/tx_ack_o     next read byte, consumed in the tx_ack_o cycle
//   nack_o, start_o, stop_o   one-cycle bus event pulses
//   busy_o, rw_o        transfer-in-progress flag, R/W bit of the last matched address
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0]  ADDR   = 7'h50,
  parameter int unsigned FILTER = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i2c_scl,
  inout  wire logic  i2c_sda,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_ack_o,
  output logic       nack_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       rw_o
);

  localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_e;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_d1_q;
  logic [1:0][CW-1:0] agree_cnt_q;

  // A filtered level only follows the synchronized input after it has
  // disagreed with the current level for FILTER consecutive samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      filt_q      <= '1;
      filt_d1_q   <= '1;
      agree_cnt_q <= '0;
    end else begin
      sync1_q   <= {i2c_sda, i2c_scl};
      sync2_q   <= sync1_q;
      filt_d1_q <= filt_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          agree_cnt_q[i] <= '0;
        end else if (agree_cnt_q[i] == CW'(FILTER - 1)) begin
          filt_q[i]      <= sync2_q[i];
          agree_cnt_q[i] <= '0;
        end else begin
          agree_cnt_q[i] <= agree_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl, scl_prev, sda, sda_prev;
  logic scl_rise, scl_fall, bus_start, bus_stop;

  assign scl      = filt_q[0];
  assign scl_prev = filt_d1_q[0];
  assign sda      = filt_q[1];
  assign sda_prev = filt_d1_q[1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  // START/STOP need SCL high in both the previous and current sample, so an
  // SDA edge coinciding with an SCL edge is treated as ordinary data.
  assign bus_start = scl & scl_prev & sda_prev & ~sda;
  assign bus_stop  = scl & scl_prev & ~sda_prev & sda;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       ack_seen_q, ack_seen_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;
  logic       tx_ack;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      ack_seen_q <= 1'b0;
      rx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      ack_seen_q <= ack_seen_d;
      rx_valid_q <= rx_valid_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    ack_seen_d = ack_seen_q;
    rx_valid_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    nack_d     = 1'b0;
    tx_ack     = 1'b0;

    if (bus_start) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      start_d   = 1'b1;
    end else if (bus_stop) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_ADDR, S_RX: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == S_RX) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = S_RX_ACK;
            end else if (shreg_q[7:1] == ADDR) begin
              rw_d     = shreg_q[0];
              busy_d   = 1'b1;
              sda_oe_d = 1'b1;
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_RX;
            if (rw_q) begin
              shreg_d   = tx_data_i;
              tx_ack    = 1'b1;
              sda_oe_d  = ~tx_data_i[7];
              bit_cnt_d = 4'd1;
              state_d   = S_TX;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_RX;
          end
        end
        S_TX: begin
          // bit_cnt counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d   = 1'b0;
              ack_seen_d = 1'b0;
              state_d    = S_TX_ACK;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oe_d  = ~shreg_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            if (sda) begin
              nack_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end else begin
              ack_seen_d = 1'b1;
            end
          end else if (scl_fall && ack_seen_q) begin
            shreg_d   = tx_data_i;
            tx_ack    = 1'b1;
            sda_oe_d  = ~tx_data_i[7];
            bit_cnt_d = 4'd1;
            state_d   = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sda    = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ack_o   = tx_ack;
  assign nack_o     = nack_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned Q = 10;  // quarter bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_sda_low;
  logic       glitch_en;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ack, nack, start_p, stop_p, busy, rw;
  logic [7:0] tx_data;
  logic [7:0] tx_mem [256];
  logic [7:0] tx_idx = 8'd0;
  logic [7:0] rx_log [256];

  int unsigned checks = 0, failures = 0;
  int unsigned n_start = 0, n_stop = 0, n_txack = 0, n_nack = 0, n_rxv = 0;

  always #5 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  assign tx_data = tx_mem[tx_idx];

  i2c_target #(.ADDR(7'h50), .FILTER(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .i2c_scl(scl), .i2c_sda(sda_bus),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_data_i(tx_data),
    .tx_ack_o(tx_ack), .nack_o(nack), .start_o(start_p), .stop_o(stop_p),
    .busy_o(busy), .rw_o(rw)
  );

  // Local side: advance to the next read byte after each consumption.
  always @(posedge clk) if (tx_ack) tx_idx <= tx_idx + 8'd1;

  always @(negedge clk) begin
    if (start_p) n_start++;
    if (stop_p)  n_stop++;
    if (tx_ack)  n_txack++;
    if (nack)    n_nack++;
    if (rx_valid) begin
      rx_log[8'(n_rxv)] = rx_data;
      n_rxv++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference rule: a target answers only its own address, never general call.
  function automatic bit addr_match(input logic [7:0] ab);
    return ab[7:1] == 7'h50;
  endfunction

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_cyc(Q); m_sda_low = 1'b0; wait_cyc(Q); scl = 1'b1; wait_cyc(Q);
    end
    m_sda_low = 1'b1; wait_cyc(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(Q); m_sda_low = 1'b1; wait_cyc(Q); scl = 1'b1;
    wait_cyc(Q); m_sda_low = 1'b0; wait_cyc(2*Q);
  endtask

  // One bit slot; b=1 releases SDA. Returns the bus level mid-high.
  task automatic put_bit(input logic b, output logic seen);
    wait_cyc(Q);
    m_sda_low = ~b;
    if (glitch_en) begin
      scl = 1'b1; wait_cyc(2); scl = 1'b0; wait_cyc(Q - 2);
    end else wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    seen = sda_bus;
    if (glitch_en && b) begin
      m_sda_low = 1'b1; wait_cyc(2); m_sda_low = 1'b0; wait_cyc(Q - 2);
    end else wait_cyc(Q);
    scl = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic ack_bit,
                          output logic [7:0] seen, output logic ack_seen);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      put_bit(b[i], v);
      seen[i] = v;
    end
    put_bit(ack_bit, ack_seen);
  endtask

  // Full START..STOP transfer; reads ACK every byte except the last.
  task automatic run_txn(input string tag, input logic [7:0] ab, input int unsigned n,
                         input logic [31:0] dat, input bit exp_match);
    int unsigned s0, p0, ta0, nk0, rv0;
    logic [7:0]  base, got_b, junk;
    logic        a, prev_rw, is_rd;
    logic [3:0]  acks, exp_acks;
    logic [31:0] got_all, exp_rd, rx_all, exp_rx;
    is_rd = ab[0];
    s0 = n_start; p0 = n_stop; ta0 = n_txack; nk0 = n_nack; rv0 = n_rxv;
    base = tx_idx; prev_rw = rw;
    acks = '0; exp_acks = '0; got_all = '0; exp_rd = '0; rx_all = '0; exp_rx = '0;
    for (int unsigned k = 0; k < n; k++) tx_mem[base + 8'(k)] = dat[8*k +: 8];
    bus_start();
    put_byte(ab, 1'b1, junk, a);
    chk({tag, "_addr_ack"}, {31'd0, a}, {31'd0, !exp_match});
    chk({tag, "_busy_mid"}, {31'd0, busy}, {31'd0, exp_match});
    chk({tag, "_rw"}, {31'd0, rw}, {31'd0, exp_match ? is_rd : prev_rw});
    for (int unsigned k = 0; k < n; k++) begin
      if (is_rd) begin
        put_byte(8'hFF, (k == n - 1), got_b, a);
        got_all[8*k +: 8] = got_b;
        exp_rd[8*k +: 8]  = exp_match ? dat[8*k +: 8] : 8'hFF;
      end else begin
        put_byte(dat[8*k +: 8], 1'b1, junk, a);
        acks[k]     = a;
        exp_acks[k] = !exp_match;
        if (exp_match) exp_rx[8*k +: 8] = dat[8*k +: 8];
      end
    end
    bus_stop();
    for (int unsigned k = 0; k < n; k++) rx_all[8*k +: 8] = rx_log[8'(rv0 + k)];
    if (is_rd) chk({tag, "_read_bytes"}, got_all, exp_rd);
    else       chk({tag, "_data_acks"}, {28'd0, acks}, {28'd0, exp_acks});
    chk({tag, "_rx_count"}, n_rxv - rv0, (exp_match && !is_rd) ? n : 0);
    if (exp_match && !is_rd) chk({tag, "_rx_bytes"}, rx_all, exp_rx);
    chk({tag, "_txack_count"}, n_txack - ta0, (exp_match && is_rd) ? n : 0);
    chk({tag, "_nack_count"}, n_nack - nk0, (exp_match && is_rd) ? 1 : 0);
    chk({tag, "_start_count"}, n_start - s0, 1);
    chk({tag, "_stop_count"}, n_stop - p0, 1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sda_released"}, {31'd0, sda_bus}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  ab;
    int unsigned n;
    logic [31:0] dat;    // byte k in bits [8k+7:8k]
    bit          match;  // expected address acknowledge
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0]  got_b, junk, ab;
    logic        a, v;
    int unsigned s0, p0;
    rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; glitch_en = 1'b0;

    vecs[0] = '{"write", 8'hA0, 2, 32'h0000C33C, 1'b1};
    vecs[1] = '{"read", 8'hA1, 2, 32'h0000815A, 1'b1};
    vecs[2] = '{"mismatch", 8'hA2, 1, 32'h00000011, 1'b0};
    vecs[3] = '{"gencall", 8'h00, 1, 32'h00000055, 1'b0};
    vecs[4] = '{"write3", 8'hA0, 3, 32'h008000FF, 1'b1};
    vecs[5] = '{"read3", 8'hA1, 3, 32'h007FFE01, 1'b1};
    vecs[6] = '{"mismatch_rd", 8'hA3, 2, 32'h00001234, 1'b0};

    wait_cyc(4);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_pulses", {27'd0, rx_valid, tx_ack, nack, start_p, stop_p}, 32'd0);
    chk("reset_busy_rw", {30'd0, busy, rw}, 32'd0);
    chk("reset_sda", {31'd0, sda_bus}, 32'd1);
    rst_n = 1'b1;
    wait_cyc(2*Q);

    foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].ab, vecs[i].n, vecs[i].dat, vecs[i].match);

    // Repeated START: write one byte, then turn around into a one-byte read.
    s0 = n_start; p0 = n_stop;
    tx_mem[tx_idx] = 8'h96;
    bus_start();
    put_byte(8'hA0, 1'b1, junk, a);
    chk("rs_addr_w_ack", {31'd0, a}, 32'd0);
    chk("rs_rw_write", {31'd0, rw}, 32'd0);
    put_byte(8'h10, 1'b1, junk, a);
    chk("rs_data_ack", {31'd0, a}, 32'd0);
    bus_start();
    put_byte(8'hA1, 1'b1, junk, a);
    chk("rs_addr_r_ack", {31'd0, a}, 32'd0);
    chk("rs_rw_read", {31'd0, rw}, 32'd1);
    put_byte(8'hFF, 1'b1, got_b, a);
    chk("rs_read_byte", {24'd0, got_b}, 32'h96);
    chk("rs_start_count", n_start - s0, 2);
    chk("rs_no_stop_between", n_stop - p0, 0);
    bus_stop();
    chk("rs_stop_count", n_stop - p0, 1);
    chk("rs_rx_data", {24'd0, rx_data}, 32'h10);

    // Short pulses on both lines inside every bit slot must be ignored.
    glitch_en = 1'b1;
    run_txn("glitch_wr", 8'hA0, 2, 32'h0000A55A, 1'b1);
    run_txn("glitch_rd", 8'hA1, 2, 32'h0000E718, 1'b1);
    glitch_en = 1'b0;

    // Reset while the target is holding the address ACK.
    bus_start();
    ab = 8'hA0;
    for (int i = 7; i >= 0; i--) put_bit(ab[i], v);
    m_sda_low = 1'b0;
    wait_cyc(Q);
    chk("rst_ack_held", {31'd0, sda_bus}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_released", {31'd0, sda_bus}, 32'd1);
    chk("rst_outputs", {21'd0, rx_data, rx_valid, tx_ack, nack, start_p, stop_p, busy, rw}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(Q); scl = 1'b1; wait_cyc(2*Q);
    run_txn("post_reset", 8'hA0, 1, 32'h00000077, 1'b1);

    // Randomized transfers checked against the address/direction rules.
    for (int unsigned t = 0; t < 16; t++) begin
      logic [6:0] adr;
      adr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      ab  = {adr, 1'($urandom)};
      run_txn("rand", ab, $urandom_range(1, 3), $urandom, addr_match(ab));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
